laser_acq_sequencer: RTL and testbench
======================================

Name: laser_acq_sequencer

Overview:
Control FSM that sequences one laser particle acquisition run.
- Arms on a software start, then waits for the motor zero index.
- Holds laser_start for a programmed number of motor revolutions, pulses adc_end, and holds the detect datapath in reset.
- Then waits for the DDR vout FIFO and Aurora TX FIFO to drain before reporting done.
- Sits between the register/command interface and the ADC-interface plus particle-detect datapath, replacing ad-hoc start/end/reset wiring.

Parameters:
TCQ, 0.1, register output delay for simulation.
REV_W, 16, width of revolution target and counter.
RST_HOLD, 8, cycles laser_rst_o stays high after adc_end_o pulse (min 1).
DRAIN_TO, 65535, max cycles waiting for FIFOs to drain before timeout.

Ports:
clk_i  in  1  system clock; only clock in the block.
rst_i  in  1  synchronous active-high reset.
acq_start_i  in  1  single-cycle start request.
acq_abort_i  in  1  single-cycle abort request.
rev_target_i  in  REV_W  number of zero-flag revolutions to acquire; sampled on accepted start.
motor_zero_flag_i  in  1  motor zero index, level, already synchronous to clk_i.
ddr_vout_fifo_empty_i  in  1  DDR vout FIFO empty.
aurora_tx_emp_i  in  1  Aurora TX FIFO empty (synchronised into clk_i upstream).
laser_start_o  out  1  acquisition enable to ADC interface and detect block.
adc_end_o  out  1  single-cycle end-of-acquisition pulse.
laser_rst_o  out  1  datapath reset.
acq_busy_o  out  1  high in any state except IDLE.
acq_done_o  out  1  single-cycle completion pulse.
acq_timeout_o  out  1  sticky drain-timeout flag.
rev_cnt_o  out  REV_W  revolutions completed in current/last run.
state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values:
  - laser_start_o=0, adc_end_o=0, acq_done_o=0, acq_busy_o=0, acq_timeout_o=0, rev_cnt_o=0.
  - laser_rst_o=1: datapath is held in reset while idle.
  - state=IDLE.
- Zero-flag edge: zf_rise = motor_zero_flag_i & ~zf_d, with zf_d registered. zf_d resets to 1, so a flag already high at reset is not an edge.
- States and encoding on state_o: IDLE=0, ARM=1, ACQ=2, STOP=3, DRAIN=4, DONE=5.
- IDLE:
  - laser_rst_o=1.
  - On acq_start_i: latch rev_target_i, clear rev_cnt_o and acq_timeout_o, go to ARM.
  - If the latched target is 0, go directly to DONE; no laser_start_o is ever asserted.
- ARM:
  - laser_rst_o=0.
  - On zf_rise go to ACQ and set laser_start_o=1 on the same clock edge, so laser_start_o rises 1 cycle after the zf_rise cycle.
- ACQ:
  - Each zf_rise increments rev_cnt_o.
  - When the increment makes rev_cnt_o == target: clear laser_start_o and pulse adc_end_o for 1 cycle on the same edge, then go to STOP.
  - The counter saturates and never wraps.
- STOP:
  - laser_rst_o=1 for RST_HOLD cycles, counted from the adc_end_o pulse cycle inclusive.
  - Then go to DRAIN; laser_rst_o stays 1.
- DRAIN:
  - Cycle counter starts at 0.
  - When ddr_vout_fifo_empty_i & aurora_tx_emp_i are both high for 2 consecutive cycles, go to DONE.
  - If the counter reaches DRAIN_TO first: set acq_timeout_o and go to DONE.
- DONE:
  - Pulse acq_done_o for 1 cycle and return to IDLE.
  - acq_busy_o is high in DONE and low from IDLE onward.
- acq_start_i is ignored outside IDLE. It is not queued.
- Abort:
  - acq_abort_i in ARM or ACQ: laser_start_o=0, pulse adc_end_o, go to STOP. rev_cnt_o is held.
  - acq_abort_i in STOP, DRAIN or DONE is ignored.
  - acq_abort_i in IDLE is ignored.
- Simultaneous start and abort in IDLE: start wins. The abort is dropped.
- Simultaneous abort and final zf_rise in ACQ: a single adc_end_o pulse. rev_cnt_o is incremented to target.
- rst_i mid-run: immediate return to reset values on the next edge. No adc_end_o or acq_done_o pulse is produced.
- adc_end_o is never high for more than 1 cycle and never high while laser_start_o is high.

Test Plan:
1. Reset, then start with rev_target_i=3. Apply zero pulses (4 cycles high, 1000 cycles apart); FIFOs empty. Required response:
   - laser_start_o rises 1 cycle after the 1st zf_rise.
   - laser_start_o falls and adc_end_o pulses on the cycle after the 4th zf_rise.
   - rev_cnt_o=3.
   - laser_rst_o high 8 cycles.
   - acq_done_o 1 cycle after the 2-cycle empty qualification.
2. Start with rev_target_i=0 -> acq_done_o 2 cycles after start; laser_start_o and adc_end_o never assert.
3. Target=5, abort after 2 revolutions -> adc_end_o pulse on the next edge, rev_cnt_o=2, flow to DONE, acq_timeout_o=0.
4. Target=1, aurora_tx_emp_i held low, DRAIN_TO=100 -> acq_timeout_o=1 and acq_done_o exactly 100 cycles into DRAIN. acq_timeout_o clears on the next accepted start.
5. motor_zero_flag_i high through reset, then start -> no revolution counted until the flag falls and rises again. Second acq_start_i during ACQ is ignored; rev_cnt_o is unaffected.
6. rst_i asserted in ACQ at rev_cnt_o=1 -> next edge: laser_start_o=0, laser_rst_o=1, rev_cnt_o=0, state_o=0, no adc_end_o or acq_done_o pulse.

Source files
------------

// File: rtl/laser_acq_sequencer.sv
// laser_acq_sequencer
//   Sequences one laser particle acquisition run: arm on start, wait for the
//   motor zero index, hold laser_start for a programmed number of
//   revolutions, pulse adc_end, hold the detect datapath in reset, then wait
//   for the downstream FIFOs to drain before reporting done.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   acq_start_i              single-cycle start request (IDLE only)
//   acq_abort_i              single-cycle abort request (ARM/ACQ only)
//   rev_target_i             revolutions to acquire, sampled on start
//   motor_zero_flag_i        motor zero index level (synchronous)
//   ddr_vout_fifo_empty_i    DDR vout FIFO empty
//   aurora_tx_emp_i          Aurora TX FIFO empty
//   laser_start_o            acquisition enable
//   adc_end_o                single-cycle end-of-acquisition pulse
//   laser_rst_o              datapath reset
//   acq_busy_o               high in every state except IDLE
//   acq_done_o               single-cycle completion pulse
//   acq_timeout_o            sticky drain-timeout flag
//   rev_cnt_o                revolutions completed in current/last run
//   state_o                  current state encoding (debug)
module laser_acq_sequencer #(
    parameter real         TCQ      = 0.1,   // simulation output delay; not applied in RTL
    parameter int unsigned REV_W    = 16,
    parameter int unsigned RST_HOLD = 8,
    parameter int unsigned DRAIN_TO = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             acq_start_i,
    input  logic             acq_abort_i,
    input  logic [REV_W-1:0] rev_target_i,
    input  logic             motor_zero_flag_i,
    input  logic             ddr_vout_fifo_empty_i,
    input  logic             aurora_tx_emp_i,
    output logic             laser_start_o,
    output logic             adc_end_o,
    output logic             laser_rst_o,
    output logic             acq_busy_o,
    output logic             acq_done_o,
    output logic             acq_timeout_o,
    output logic [REV_W-1:0] rev_cnt_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        ACQ   = 3'd2,
        STOP  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // One counter serves both the STOP hold and the DRAIN timeout.
    localparam int unsigned CNT_MAX = (RST_HOLD > DRAIN_TO) ? RST_HOLD : DRAIN_TO;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);

    state_t           state_q, state_d;
    logic             zf_q;
    logic [REV_W-1:0] target_q, target_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             emp_seen_q, emp_seen_d;
    logic             laser_start_q, laser_start_d;
    logic             adc_end_q, adc_end_d;
    logic             timeout_q, timeout_d;
    logic             laser_rst_q, busy_q, done_q;

    logic zf_rise;
    logic both_empty;

    // zf_q resets to 1 so a flag already high out of reset is not an edge.
    assign zf_rise    = motor_zero_flag_i & ~zf_q;
    assign both_empty = ddr_vout_fifo_empty_i & aurora_tx_emp_i;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        rev_cnt_d     = rev_cnt_q;
        laser_start_d = laser_start_q;
        adc_end_d     = 1'b0;
        timeout_d     = timeout_q;

        case (state_q)
            IDLE: begin
                if (acq_start_i) begin
                    target_d  = rev_target_i;
                    rev_cnt_d = '0;
                    timeout_d = 1'b0;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (target_q == '0) begin
                    state_d = DONE;
                end else if (acq_abort_i) begin
                    adc_end_d = 1'b1;
                    state_d   = STOP;
                end else if (zf_rise) begin
                    laser_start_d = 1'b1;
                    state_d       = ACQ;
                end
            end
            ACQ: begin
                if (zf_rise && (rev_cnt_q != '1)) begin
                    rev_cnt_d = rev_cnt_q + 1'b1;
                end
                // Abort coinciding with the final edge still yields one pulse.
                if ((zf_rise && (rev_cnt_d == target_q)) || acq_abort_i) begin
                    laser_start_d = 1'b0;
                    adc_end_d     = 1'b1;
                    state_d       = STOP;
                end
            end
            STOP: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (both_empty && emp_seen_q) begin
                    state_d = DONE;
                end else if (cnt_q == DRAIN_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == state_q) && ((state_q == STOP) || (state_q == DRAIN))) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        // Only empties observed while in DRAIN count toward qualification.
        emp_seen_d = (state_q == DRAIN) && both_empty;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            zf_q          <= 1'b1;
            target_q      <= '0;
            rev_cnt_q     <= '0;
            cnt_q         <= '0;
            emp_seen_q    <= 1'b0;
            laser_start_q <= 1'b0;
            adc_end_q     <= 1'b0;
            timeout_q     <= 1'b0;
            laser_rst_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            zf_q          <= motor_zero_flag_i;
            target_q      <= target_d;
            rev_cnt_q     <= rev_cnt_d;
            cnt_q         <= cnt_d;
            emp_seen_q    <= emp_seen_d;
            laser_start_q <= laser_start_d;
            adc_end_q     <= adc_end_d;
            timeout_q     <= timeout_d;
            // State-decoded outputs are registered from the next state so
            // they line up with state_q without a combinational decode.
            laser_rst_q   <= !((state_d == ARM) || (state_d == ACQ));
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
        end
    end

    assign laser_start_o = laser_start_q;
    assign adc_end_o     = adc_end_q;
    assign laser_rst_o   = laser_rst_q;
    assign acq_busy_o    = busy_q;
    assign acq_done_o    = done_q;
    assign acq_timeout_o = timeout_q;
    assign rev_cnt_o     = rev_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_laser_acq_sequencer.sv
// tb_laser_acq_sequencer
//   Scoreboard bench for laser_acq_sequencer. Each run is described by a few
//   event times (zero-flag rises, abort, drain delay); the expected
//   laser_start rise, adc_end pulse and done pulse are computed from those
//   times and queued, and a monitor pops them whenever the DUT shows the
//   corresponding output.
module tb_laser_acq_sequencer;

    localparam int unsigned REV_W    = 16;
    localparam int          RST_HOLD = 8;
    localparam int          DRAIN_TO = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort_r;
    logic [REV_W-1:0] target;
    logic             flag;
    logic             ddr_emp;
    logic             aur_emp;

    logic             laser_start_o;
    logic             adc_end_o;
    logic             laser_rst_o;
    logic             acq_busy_o;
    logic             acq_done_o;
    logic             acq_timeout_o;
    logic [REV_W-1:0] rev_cnt_o;
    logic [2:0]       state_o;

    always #5 clk = ~clk;

    laser_acq_sequencer #(
        .REV_W   (REV_W),
        .RST_HOLD(RST_HOLD),
        .DRAIN_TO(DRAIN_TO)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .acq_start_i          (start),
        .acq_abort_i          (abort_r),
        .rev_target_i         (target),
        .motor_zero_flag_i    (flag),
        .ddr_vout_fifo_empty_i(ddr_emp),
        .aurora_tx_emp_i      (aur_emp),
        .laser_start_o        (laser_start_o),
        .adc_end_o            (adc_end_o),
        .laser_rst_o          (laser_rst_o),
        .acq_busy_o           (acq_busy_o),
        .acq_done_o           (acq_done_o),
        .acq_timeout_o        (acq_timeout_o),
        .rev_cnt_o            (rev_cnt_o),
        .state_o              (state_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        int rev;
    } adc_exp_t;

    typedef struct {
        int cyc;
        int rev;
        bit to;
    } done_exp_t;

    int        ls_q[$];
    adc_exp_t  adc_q[$];
    done_exp_t done_q[$];

    typedef struct {
        int T;            // revolution target
        int f;            // first zero-flag rise, cycles after start
        int P;            // zero-flag period
        int H;            // zero-flag high width (< P)
        int abort_m;      // abort after this many revolutions (-1: none)
        int g;            // abort offset after rise abort_m (0: same cycle)
        int w;            // aurora empty rises w cycles into DRAIN (0: always empty)
        bit pre_high;     // flag already high when start is issued
        bit extra_start;  // second start while acquiring
        bit stray_abort;  // abort while in STOP
        bit start_abort;  // abort together with start
        int rst_rev;      // reset 2 cycles after rise rst_rev (-1: none)
    } run_t;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got pulse expected none at cycle %0d", name, cyc);
    endtask

    function automatic run_t mk(input int T, input int f, input int P, input int H, input int w);
        run_t rn;
        rn.T = T; rn.f = f; rn.P = P; rn.H = H; rn.w = w;
        rn.abort_m = -1; rn.g = 0;
        rn.pre_high = 1'b0; rn.extra_start = 1'b0;
        rn.stray_abort = 1'b0; rn.start_abort = 1'b0;
        rn.rst_rev = -1;
        return rn;
    endfunction

    // Monitor: pops an expectation whenever the DUT presents an event.
    initial begin
        bit ls_prev  = 1'b0;
        bit adc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (laser_start_o && !ls_prev) begin
                if (ls_q.size() == 0) unexpected("ls_rise");
                else begin
                    chk("ls_rise_cycle", cyc, ls_q.pop_front());
                    chk("ls_rst_low", int'(laser_rst_o), 0);
                    chk("ls_state", int'(state_o), 2);
                end
            end
            if (adc_end_o) begin
                chk("adc_vs_ls", int'(laser_start_o), 0);
                chk("adc_width", int'(adc_prev), 0);
                if (adc_q.size() == 0) unexpected("adc_end");
                else begin
                    adc_exp_t ea;
                    ea = adc_q.pop_front();
                    chk("adc_cycle", cyc, ea.cyc);
                    chk("adc_rev", int'(rev_cnt_o), ea.rev);
                    chk("adc_state", int'(state_o), 3);
                    chk("adc_rst_high", int'(laser_rst_o), 1);
                end
            end
            if (acq_done_o) begin
                if (done_q.size() == 0) unexpected("acq_done");
                else begin
                    done_exp_t ed;
                    ed = done_q.pop_front();
                    chk("done_cycle", cyc, ed.cyc);
                    chk("done_timeout", int'(acq_timeout_o), int'(ed.to));
                    chk("done_rev", int'(rev_cnt_o), ed.rev);
                    chk("done_busy", int'(acq_busy_o), 1);
                    chk("done_state", int'(state_o), 5);
                end
            end
            ls_prev  = laser_start_o;
            adc_prev = adc_end_o;
        end
    end

    task automatic do_run(input run_t rn);
        int s, c, a, e, d0, done_c, end_c, rst_at, rev, n_rise, r0;
        bit aborted, to, is_rst, pulse;
        int r[$];
        @(posedge clk); #1;
        s       = cyc;
        is_rst  = (rn.rst_rev >= 0);
        aborted = (rn.abort_m >= 0) && (rn.T > 0) && !is_rst;
        if (rn.T == 0)    n_rise = 0;
        else if (is_rst)  n_rise = rn.rst_rev + 1;
        else if (aborted) n_rise = rn.abort_m + 1;
        else              n_rise = rn.T + 1;
        for (int k = 0; k < n_rise; k++) r.push_back(s + rn.f + k * rn.P);
        r0 = (n_rise > 0) ? r[0] : -100;
        a = -100; e = -100; d0 = -100; rst_at = -100; rev = 0; to = 1'b0; done_c = -100;
        if (rn.T == 0) begin
            done_c = s + 2;
            end_c  = s + 4;
        end else if (is_rst) begin
            rst_at = r[rn.rst_rev] + 2;
            end_c  = rst_at + 3;
        end else begin
            if (aborted) begin
                a   = r[rn.abort_m] + rn.g;
                e   = a + 1;
                rev = rn.abort_m;
            end else begin
                e   = r[rn.T] + 1;
                rev = rn.T;
            end
            d0     = e + RST_HOLD;
            to     = (rn.w > DRAIN_TO - 2);
            done_c = to ? d0 + DRAIN_TO : d0 + rn.w + 2;
            end_c  = done_c + 2;
        end
        if (rn.T > 0) ls_q.push_back(r0 + 1);
        if (rn.T > 0 && !is_rst) adc_q.push_back('{e, rev});
        if (!is_rst) done_q.push_back('{done_c, rev, to});
        target = REV_W'(rn.T);

        forever begin
            c = cyc;
            pulse = rn.pre_high && (c <= s + rn.f - 2);
            foreach (r[k]) if (c >= r[k] && c < r[k] + rn.H) pulse = 1'b1;
            flag    = pulse;
            start   = (c == s) || (rn.extra_start && rn.T > 0 && c == r0 + 2);
            abort_r = (aborted && c == a) || (rn.start_abort && c == s)
                      || (rn.stray_abort && rn.T > 0 && !is_rst && c == e + 1);
            ddr_emp = !(rn.T > 0 && !is_rst && c > r0 && c < e);
            aur_emp = (rn.T == 0 || is_rst || rn.w == 0) ? 1'b1 : (c >= d0 + rn.w);
            rst     = is_rst && (c == rst_at);
            if (c == s + 1) begin
                @(negedge clk);
                chk("arm_state", int'(state_o), 1);
                chk("arm_busy", int'(acq_busy_o), 1);
                chk("arm_rst_low", int'(laser_rst_o), 0);
                chk("arm_rev_clear", int'(rev_cnt_o), 0);
                chk("arm_timeout_clear", int'(acq_timeout_o), 0);
            end else if (is_rst && c == rst_at) begin
                @(negedge clk);
                chk("rst_pre_rev", int'(rev_cnt_o), rn.rst_rev);
            end else if (is_rst && c == rst_at + 1) begin
                @(negedge clk);
                chk("rst_ls", int'(laser_start_o), 0);
                chk("rst_laser_rst", int'(laser_rst_o), 1);
                chk("rst_rev", int'(rev_cnt_o), 0);
                chk("rst_state", int'(state_o), 0);
                chk("rst_busy", int'(acq_busy_o), 0);
            end else if (c == end_c) begin
                @(negedge clk);
                chk("end_state", int'(state_o), 0);
                chk("end_busy", int'(acq_busy_o), 0);
                chk("end_laser_rst", int'(laser_rst_o), 1);
                chk("end_timeout_sticky", int'(acq_timeout_o), int'(to));
                break;
            end
            @(posedge clk); #1;
        end
        chk("events_pending", ls_q.size() + adc_q.size() + done_q.size(), 0);
        ls_q.delete(); adc_q.delete(); done_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        run_t rn;
        int sel;
        rst = 1'b1; start = 1'b0; abort_r = 1'b0; target = '0;
        flag = 1'b1; ddr_emp = 1'b1; aur_emp = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ls", int'(laser_start_o), 0);
        chk("reset_adc", int'(adc_end_o), 0);
        chk("reset_done", int'(acq_done_o), 0);
        chk("reset_busy", int'(acq_busy_o), 0);
        chk("reset_timeout", int'(acq_timeout_o), 0);
        chk("reset_rev", int'(rev_cnt_o), 0);
        chk("reset_laser_rst", int'(laser_rst_o), 1);
        chk("reset_state", int'(state_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Flag high through reset; second start during ACQ.
        rn = mk(2, 4, 9, 3, 5); rn.pre_high = 1'b1; rn.extra_start = 1'b1; do_run(rn);
        // Basic run, long revolution period.
        rn = mk(3, 3, 1000, 4, 0); do_run(rn);
        // Zero target.
        rn = mk(0, 1, 6, 1, 0); do_run(rn);
        // Abort after two revolutions.
        rn = mk(5, 2, 12, 3, 0); rn.abort_m = 2; rn.g = 5; do_run(rn);
        // Drain timeout, then a run whose start must clear the flag.
        rn = mk(1, 2, 10, 2, 150); do_run(rn);
        // Abort coinciding with the final zero-flag rise.
        rn = mk(2, 2, 8, 2, 3); rn.abort_m = 2; rn.g = 0; do_run(rn);
        // Reset in the middle of ACQ at one revolution.
        rn = mk(3, 2, 10, 2, 0); rn.rst_rev = 1; do_run(rn);
        // Drain qualification on the last cycle before timeout, and one too late.
        rn = mk(1, 1, 7, 2, DRAIN_TO - 2); do_run(rn);
        rn = mk(1, 1, 7, 2, DRAIN_TO - 1); do_run(rn);
        // Start with abort in IDLE, abort ignored in STOP.
        rn = mk(2, 1, 6, 1, 4); rn.start_abort = 1'b1; rn.stray_abort = 1'b1; do_run(rn);

        for (int i = 0; i < 40; i++) begin
            rn = mk(($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(4, 1)),
                    int'($urandom_range(5, 1)), int'($urandom_range(20, 6)),
                    int'($urandom_range(4, 1)), 0);
            if (rn.T > 0) begin
                sel = int'($urandom_range(9, 0));
                if (sel < 3) begin
                    rn.abort_m = int'($urandom_range(rn.T - 1, 0));
                    rn.g       = int'($urandom_range(rn.P - 1, 1));
                end else if (sel == 3) begin
                    rn.abort_m = rn.T;
                    rn.g       = 0;
                end
            end
            sel = int'($urandom_range(9, 0));
            if (sel < 3)       rn.w = 0;
            else if (sel < 7)  rn.w = int'($urandom_range(40, 1));
            else if (sel == 7) rn.w = DRAIN_TO - 2;
            else if (sel == 8) rn.w = DRAIN_TO - 1;
            else               rn.w = DRAIN_TO + 20;
            rn.pre_high    = (rn.f >= 2) && ($urandom_range(3, 0) == 0);
            rn.extra_start = ($urandom_range(2, 0) == 0);
            rn.stray_abort = ($urandom_range(2, 0) == 0);
            rn.start_abort = ($urandom_range(4, 0) == 0);
            do_run(rn);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
